// File: rtl/search_window_loader.sv
// Streams one WINDOW_SIZE x WINDOW_SIZE search window into the window memory.
// Optional abort input enabled by defining SWL_ABORT_EN.
module search_window_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int WINDOW_SIZE = 31,
    localparam int D  = WINDOW_SIZE * WINDOW_SIZE,
    localparam int AW = $clog2(D)
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_start,
    input  logic                  in_pixel_valid,
    input  logic [DATA_WIDTH-1:0] in_pixel_data,
    output logic                  out_pixel_ready,
    output logic                  out_write_en,
    output logic [AW-1:0]         out_write_addr,
    output logic [DATA_WIDTH-1:0] out_write_data,
    output logic                  out_busy,
    output logic                  out_done
`ifdef SWL_ABORT_EN
    ,
    input  logic                  in_abort
`endif
);

    localparam int CW = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_n;
    logic [CW-1:0] col;
    logic [CW-1:0] col_n;
    logic          accept;
    logic          last;
    logic          abort;

`ifdef SWL_ABORT_EN
    assign abort = in_abort;
`else
    assign abort = 1'b0;
`endif

    // Final pixel sits in the last column of the last row.
    assign last = (addr == AW'(D - 1)) && (col == CW'(WINDOW_SIZE - 1));

    always_comb begin
        state_n = state;
        addr_n  = addr;
        col_n   = col;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_start) begin
                    state_n = LOAD;
                    addr_n  = '0;
                    col_n   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                    addr_n  = '0;
                    col_n   = '0;
                end else if (in_pixel_valid && out_pixel_ready) begin
                    accept = 1'b1;
                    if (last) begin
                        state_n = DONE;
                    end else begin
                        addr_n = addr + 1'b1;
                        col_n  = (col == CW'(WINDOW_SIZE - 1)) ? '0 : col + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state           <= IDLE;
            addr            <= '0;
            col             <= '0;
            out_pixel_ready <= 1'b0;
            out_write_en    <= 1'b0;
            out_write_addr  <= '0;
            out_write_data  <= '0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
        end else begin
            state           <= state_n;
            addr            <= addr_n;
            col             <= col_n;
            out_pixel_ready <= (state_n == LOAD);
            // Busy stays high through the done cycle.
            out_busy        <= (state_n != IDLE) || (state == DONE);
            out_done        <= (state == DONE);
            out_write_en    <= accept;
            if (accept) begin
                out_write_addr <= addr;
                out_write_data <= in_pixel_data;
            end
        end
    end

endmodule

// File: doc/search_window_loader.md
# search_window_loader

Streams one motion-estimation search window (WINDOW_SIZE × WINDOW_SIZE pixels, raster order) from the frame-fetch path into the search window memory. The block accepts pixels over a valid/ready handshake and generates linear write addresses, write enables and write data for the memory's write port. On completion it pulses a done strobe so the SAD/address-generation stage may begin two-port reads. It sits directly upstream of the search window memory.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- WINDOW_SIZE, 31, window edge length in pixels; depth D = WINDOW_SIZE*WINDOW_SIZE (961)
- AW (localparam), $clog2(D), address width (10 at defaults)

- in_clk  input  1  sole clock, rising edge
- in_rst_n  input  1  asynchronous, active-low reset
- in_start  input  1  begin loading a new window; sampled only in IDLE
- in_pixel_valid  input  1  in_pixel_data holds a valid pixel
- in_pixel_data  input  DATA_WIDTH  pixel, raster order (row 0 col 0 first)
- out_pixel_ready  output  1  block accepts a pixel this cycle
- out_write_en  output  1  memory write enable (registered)
- out_write_addr  output  AW  memory write address (registered)
- out_write_data  output  DATA_WIDTH  memory write data (registered)
- out_busy  output  1  load in progress; downstream must not read memory
- out_done  output  1  one-cycle pulse: full window committed to memory
- in_abort  input  1  only with SWL_ABORT_EN (see Configuration)

## Operation
- States: IDLE, LOAD, DONE. All outputs are registered.
- IDLE: out_pixel_ready=0, out_busy=0. in_start=1 → LOAD; address counter and column counter cleared to 0.
- LOAD: out_pixel_ready=1, out_busy=1. Accept = in_pixel_valid & out_pixel_ready. On accept: next cycle out_write_en=1, out_write_addr=current address, out_write_data=in_pixel_data; address increments by 1. Column counter wraps WINDOW_SIZE-1 → 0 (used only as a consistency check: column 0 coincides with address multiples of WINDOW_SIZE). No accept → out_write_en=0 next cycle; counters hold.
- Final accept (address = D-1): state → DONE, out_pixel_ready deasserts in the following cycle, so exactly D pixels are taken per load.
- DONE: one cycle, out_done=1, out_busy=1, then → IDLE.
- in_start is ignored in LOAD and DONE; in_pixel_valid is ignored in IDLE and DONE (no write, no counter change).
- Address never exceeds D-1; no wrap to 0 within a load.

## Timing
- Reset (async assert, sync release): state=IDLE; out_pixel_ready=0, out_write_en=0, out_write_addr=0, out_write_data=0, out_busy=0, out_done=0; counters 0.
- in_start at edge k → LOAD at k+1; out_pixel_ready=1 during cycle k+1.
- Pixel accepted at edge n → out_write_en high during cycle n+1 (memory commits at edge n+2).
- Last accept at edge m → last out_write_en in cycle m+1 → out_done high in cycle m+2 → IDLE, out_busy=0 in cycle m+3.
- Minimum load time at full throughput: D+3 cycles from start to out_busy low.
- Reset mid-load: immediate return to IDLE, outputs at reset values; partial window contents in memory are undefined; no out_done.

## Configuration
- SWL_ABORT_EN defined: adds input in_abort. In LOAD, in_abort=1 at an edge → IDLE next cycle; any pixel presented in that same cycle is not accepted; out_write_en=0, out_done not pulsed, counters cleared. in_abort ignored in IDLE/DONE.
- SWL_ABORT_EN undefined: port absent; a load only ends via D accepts or reset.

## Test plan
- Reset then idle: hold in_rst_n=0 5 cycles, release, valid=1 with no start → out_pixel_ready=0, no out_write_en, out_done=0 for 20 cycles.
- Full-rate load: start, valid held 1, data = address mod 256 → 961 writes, addresses 0..960 consecutive, data matches, out_done single pulse 2 cycles after last accept.
- Bubbled load: valid toggles pseudo-randomly (~50%) → still exactly 961 writes in order, no gaps in addresses, no writes in bubble cycles.
- Start during LOAD and valid after completion: start pulsed at pixel 100, valid held after 961st accept → no restart, no 962nd write, ready low after final accept.
- Async reset at pixel 500: in_rst_n pulled low mid-cycle → outputs zero immediately, out_done never pulses; subsequent start loads from address 0.
- SWL_ABORT_EN: abort at pixel 300 → no write for that cycle, IDLE next cycle, no out_done; new start loads 961 pixels from address 0.
